// File: rtl/nabp_filter_pkg.sv
// nabp_filter_pkg: Ram-Lak coefficients, filter FSM states and width helpers
package nabp_filter_pkg;
  localparam real PI = 3.14159265358979;
  typedef enum logic [1:0] {IDLE, READ, FLUSH, DRAIN} state_t;
  function automatic int acc_width(int data_len, int coeff_len, int order);
    return data_len + coeff_len + $clog2(order + 1);
  endfunction
  function automatic int s_width(int line_size);
    return $clog2(line_size + 1);
  endfunction
  function automatic int ram_lak(int k, int frac);
    real v;
    if (k == 0) return ((1 << frac) + 2) / 4;
    if (k % 2 == 0) return 0;
    v = $itor(1 << frac) / (PI * PI * $itor(k * k));
    return -$rtoi(v + 0.5);
  endfunction
endpackage

// File: rtl/nabp_projection_filter_if.sv
// nabp_projection_filter_if: kick/status, raw RAM read port and filtered output bus
interface nabp_projection_filter_if #(
  parameter int DATA_LEN = 8,
  parameter int FILTERED_LEN = 16,
  parameter int S_LEN = 8
);
  logic kick;
  logic busy;
  logic [S_LEN-1:0] raw_s;
  logic [DATA_LEN-1:0] raw_val;
  logic out_valid;
  logic [S_LEN-1:0] out_s;
  logic signed [FILTERED_LEN-1:0] out_val;
  logic done;
  modport master (output kick, raw_val, input busy, raw_s, out_valid, out_s, out_val, done);
  modport slave (input kick, raw_val, output busy, raw_s, out_valid, out_s, out_val, done);
endinterface

// File: rtl/nabp_filter_mac.sv
// nabp_filter_mac: symmetric FIR pre-add/multiply/sum, floor shift, saturate, one output register
module nabp_filter_mac import nabp_filter_pkg::*; #(
  parameter int DATA_LEN = 8,
  parameter int FILTERED_LEN = 16,
  parameter int ORDER = 8,
  parameter int COEFF_LEN = 12,
  parameter int COEFF_FRAC = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic [ORDER:0][DATA_LEN-1:0] win,
  input  logic [ORDER:0][COEFF_LEN-1:0] coeff,
  output logic signed [FILTERED_LEN-1:0] y
);
  localparam int ACC_W = acc_width(DATA_LEN, COEFF_LEN, ORDER);
  localparam int H = ORDER / 2;
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((64'sd1 <<< (FILTERED_LEN - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;
  logic signed [ACC_W-1:0] acc, sh;
  logic signed [FILTERED_LEN-1:0] y_d, y_q;
  always_comb begin
    acc = ACC_W'($signed({1'b0, win[H]})) * ACC_W'($signed(coeff[H]));
    for (int m = 0; m < H; m++)
      acc = acc + ACC_W'($signed({2'b0, win[m]} + {2'b0, win[ORDER-m]})) * ACC_W'($signed(coeff[m]));
    sh = acc >>> COEFF_FRAC;
    y_d = !en ? y_q : sh > MAX_V ? FILTERED_LEN'(MAX_V) : sh < MIN_V ? FILTERED_LEN'(MIN_V) : FILTERED_LEN'(sh);
  end
  always_ff @(posedge clk)
    if (!reset_n) y_q <= '0;
    else y_q <= y_d;
  assign y = y_q;
endmodule

// File: rtl/nabp_projection_filter.sv
// nabp_projection_filter: streams one raw line through the Ram-Lak FIR, one tagged sample per cycle
module nabp_projection_filter import nabp_filter_pkg::*; #(
  parameter int DATA_LEN = 8,
  parameter int FILTERED_LEN = 16,
  parameter int LINE_SIZE = 128,
  parameter int ORDER = 8,
  parameter int COEFF_LEN = 12,
  parameter int COEFF_FRAC = 8,
  parameter int S_LEN = s_width(LINE_SIZE)
) (
  input logic clk,
  input logic reset_n,
  nabp_projection_filter_if.slave bus
);
  localparam logic [S_LEN-1:0] LAST = S_LEN'(LINE_SIZE - 1);
  localparam logic [S_LEN-1:0] FL_LAST = S_LEN'(ORDER / 2 - 1);
  localparam logic [S_LEN:0] HALF = (S_LEN + 1)'(ORDER / 2);
  state_t state_q, state_d;
  logic [S_LEN-1:0] raw_s_q, raw_s_d, fl_cnt_q, fl_cnt_d, mac_s_q, mac_s_d, out_s_q, out_s_d;
  logic [S_LEN:0] push_cnt_q, push_cnt_d;
  logic [ORDER:0][DATA_LEN-1:0] win_q, win_d;
  logic [ORDER:0][COEFF_LEN-1:0] coeff;
  logic rd_v_q, rd_v_d, fl_v_q, fl_v_d, mac_v_q, mac_v_d, mac_last_q, mac_last_d;
  logic out_valid_q, out_valid_d, done_q, done_d, push;
  logic signed [FILTERED_LEN-1:0] y;
  for (genvar i = 0; i <= ORDER; i++) begin : g_coeff
    localparam int HK = ram_lak(i - ORDER / 2, COEFF_FRAC);
    assign coeff[i] = COEFF_LEN'(HK);
  end
  always_comb begin
    state_d = state_q;
    raw_s_d = raw_s_q;
    fl_cnt_d = fl_cnt_q;
    push_cnt_d = push_cnt_q;
    win_d = win_q;
    case (state_q)
      IDLE: if (bus.kick) begin
        state_d = READ;
        raw_s_d = '0;
        push_cnt_d = '0;
        win_d = '0;
      end
      READ: begin
        state_d = raw_s_q == LAST ? FLUSH : READ;
        raw_s_d = raw_s_q == LAST ? raw_s_q : raw_s_q + 1'b1;
        fl_cnt_d = '0;
      end
      FLUSH: begin
        state_d = fl_cnt_q == FL_LAST ? DRAIN : FLUSH;
        fl_cnt_d = fl_cnt_q + 1'b1;
      end
      default: state_d = done_q ? IDLE : DRAIN;
    endcase
    // pushes trail the FSM by one cycle because raw RAM data arrives a cycle after its address
    push = rd_v_q | fl_v_q;
    if (push) begin
      win_d = {win_q[ORDER-1:0], rd_v_q ? bus.raw_val : DATA_LEN'(0)};
      push_cnt_d = push_cnt_q + 1'b1;
    end
    rd_v_d = state_q == READ;
    fl_v_d = state_q == FLUSH;
    mac_v_d = push && push_cnt_q >= HALF;
    mac_s_d = S_LEN'(push_cnt_q - HALF);
    mac_last_d = mac_v_d && mac_s_d == LAST;
    out_valid_d = mac_v_q;
    out_s_d = mac_v_q ? mac_s_q : out_s_q;
    done_d = mac_v_q && mac_last_q;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state_q <= IDLE;
      raw_s_q <= '0;
      fl_cnt_q <= '0;
      push_cnt_q <= '0;
      win_q <= '0;
      rd_v_q <= 1'b0;
      fl_v_q <= 1'b0;
      mac_v_q <= 1'b0;
      mac_s_q <= '0;
      mac_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_s_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      raw_s_q <= raw_s_d;
      fl_cnt_q <= fl_cnt_d;
      push_cnt_q <= push_cnt_d;
      win_q <= win_d;
      rd_v_q <= rd_v_d;
      fl_v_q <= fl_v_d;
      mac_v_q <= mac_v_d;
      mac_s_q <= mac_s_d;
      mac_last_q <= mac_last_d;
      out_valid_q <= out_valid_d;
      out_s_q <= out_s_d;
      done_q <= done_d;
    end
  nabp_filter_mac #(
    .DATA_LEN(DATA_LEN), .FILTERED_LEN(FILTERED_LEN), .ORDER(ORDER),
    .COEFF_LEN(COEFF_LEN), .COEFF_FRAC(COEFF_FRAC)
  ) u_mac (
    .clk(clk), .reset_n(reset_n), .en(mac_v_q), .win(win_q), .coeff(coeff), .y(y)
  );
  assign bus.busy = state_q != IDLE;
  assign bus.raw_s = raw_s_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_s = out_s_q;
  assign bus.out_val = y;
  assign bus.done = done_q;
endmodule

// File: tb/tb_nabp_projection_filter.sv
// tb_nabp_projection_filter: scoreboard bench, 16-bit and 6-bit output instances fed the same lines
module tb_nabp_projection_filter;
  typedef struct {int s; int v;} exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic kick = 1'b0;
  logic [7:0] mem [128];
  int hk [9] = '{0, -3, 0, -26, 64, -26, 0, -3, 0};
  exp_t qa[$], qb[$];
  int checks = 0, errors = 0, vcnt_a = 0, vcnt_b = 0;
  always #5 clk = ~clk;
  nabp_projection_filter_if #(.DATA_LEN(8), .FILTERED_LEN(16), .S_LEN(8)) a_if ();
  nabp_projection_filter_if #(.DATA_LEN(8), .FILTERED_LEN(6), .S_LEN(8)) b_if ();
  nabp_projection_filter #(.FILTERED_LEN(16)) dut_a (.clk(clk), .reset_n(reset_n), .bus(a_if));
  nabp_projection_filter #(.FILTERED_LEN(6)) dut_b (.clk(clk), .reset_n(reset_n), .bus(b_if));
  assign a_if.kick = kick;
  assign b_if.kick = kick;
  always @(posedge clk) begin
    a_if.raw_val <= mem[a_if.raw_s[6:0]];
    b_if.raw_val <= mem[b_if.raw_s[6:0]];
  end
  task automatic chk(string tag, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int model(int s, int w);
    int acc = 0;
    int y;
    int hi = (1 << (w - 1)) - 1;
    for (int k = -4; k <= 4; k++)
      if (s + k >= 0 && s + k < 128) acc += hk[k + 4] * int'(mem[s + k]);
    y = acc >>> 8;
    return y > hi ? hi : y < -hi - 1 ? -hi - 1 : y;
  endfunction
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_if.out_valid) begin
      vcnt_a++;
      if (qa.size() == 0) chk("a_extra_valid", a_if.out_valid, 0);
      else begin
        e = qa.pop_front();
        chk("a_out_s", a_if.out_s, e.s);
        chk("a_out_val", a_if.out_val, e.v);
        chk("a_done", a_if.done, e.s == 127);
      end
    end else chk("a_done_idle", a_if.done, 0);
  end
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_if.out_valid) begin
      vcnt_b++;
      if (qb.size() == 0) chk("b_extra_valid", b_if.out_valid, 0);
      else begin
        e = qb.pop_front();
        chk("b_out_s", b_if.out_s, e.s);
        chk("b_out_val", b_if.out_val, e.v);
        chk("b_done", b_if.done, e.s == 127);
      end
    end else chk("b_done_idle", b_if.done, 0);
  end
  task automatic fill(int v);
    foreach (mem[i]) mem[i] = 8'(v);
  endtask
  task automatic fill_rand();
    foreach (mem[i]) mem[i] = 8'($urandom_range(0, 255));
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, a_if.busy, 0);
    chk({tag, "_valid"}, a_if.out_valid, 0);
    chk({tag, "_done"}, a_if.done, 0);
    chk({tag, "_raw_s"}, a_if.raw_s, 0);
    chk({tag, "_out_s"}, a_if.out_s, 0);
    chk({tag, "_out_val"}, a_if.out_val, 0);
    chk({tag, "_b_out_val"}, b_if.out_val, 0);
  endtask
  task automatic start_line(bit mid_kick);
    int lat = 0;
    @(negedge clk);
    chk("idle_busy", a_if.busy, 0);
    for (int s = 0; s < 128; s++) begin
      qa.push_back('{s, model(s, 16)});
      qb.push_back('{s, model(s, 6)});
    end
    vcnt_a = 0;
    vcnt_b = 0;
    kick = 1'b1;
    @(posedge clk);
    #1 kick = 1'b0;
    chk("busy", a_if.busy, 1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (a_if.out_valid) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, 8);
    if (mid_kick) begin
      repeat (20) @(negedge clk);
      kick = 1'b1;
      @(posedge clk);
      #1 kick = 1'b0;
    end
  endtask
  task automatic finish_line(bit done_kick);
    bit got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (a_if.done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", got, 1);
    if (done_kick) kick = 1'b1;
    @(posedge clk);
    #1 kick = 1'b0;
    chk("count_a", vcnt_a, 128);
    chk("count_b", vcnt_b, 128);
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    fill(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    fill(0); mem[10] = 8'd100;
    start_line(1'b0); finish_line(1'b0);
    fill(0); mem[0] = 8'd100;
    start_line(1'b1); finish_line(1'b0);
    fill(0); mem[127] = 8'd100;
    start_line(1'b0); finish_line(1'b1);
    fill(255);
    start_line(1'b0); finish_line(1'b0);
    fill(0); mem[20] = 8'd255;
    start_line(1'b0); finish_line(1'b0);
    fill_rand();
    start_line(1'b0);
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    qa.delete();
    qb.delete();
    @(negedge clk);
    chk_zero("midreset");
    repeat (160) @(negedge clk);
    chk("midreset_idle", a_if.busy, 0);
    fill_rand();
    start_line(1'b0); finish_line(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
